// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small FIFO; a byte written while idle starts its start bit on the next edge.
// Writes are never stalled: a write against a full FIFO is dropped and flagged in the sticky Overflow.

module tx_byte_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_dat,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;

    assign push   = wr_en && !full;
    assign pop    = rd_en && !empty;
    assign full   = (level == DEPTH_L);
    assign empty  = (level == '0);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (push)
            mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

module uart_tx_fifo #(
    parameter int Baudrate = 10415,
    parameter int ADDR_W   = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [7:0]      Data_in,
    input  logic            Wr_en,
    output logic            Full,
    output logic            Empty,
    output logic [ADDR_W:0] Level,
    output logic            Overflow,
    output logic            TX,
    output logic            Busy,
    output logic            Done
);
    localparam int CNT_W = (Baudrate > 2) ? $clog2(Baudrate) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(Baudrate - 1);
    localparam logic [CNT_W-1:0] BAUD_PEN  = CNT_W'(Baudrate - 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       fifo_rd_dat;
    logic             pop;
    logic             bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign pop     = !Empty && ((state == IDLE) || (state == STOP && bit_end));
    assign Busy    = (state != IDLE);

    tx_byte_fifo #(.DATA_W(8), .ADDR_W(ADDR_W)) u_fifo (
        .Clk    (Clk),
        .Reset  (Reset),
        .wr_en  (Wr_en),
        .wr_dat (Data_in),
        .rd_en  (pop),
        .rd_dat (fifo_rd_dat),
        .full   (Full),
        .empty  (Empty),
        .level  (Level)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            TX       <= 1'b1;
            Done     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            // Registered so Done is high exactly on the last stop-bit cycle.
            Done <= (state == STOP) && (baud_cnt == BAUD_PEN);
            if (Wr_en && Full)
                Overflow <= 1'b1;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shift <= fifo_rd_dat;
                        state <= START;
                        TX    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        TX       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            TX    <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            TX      <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= fifo_rd_dat;
                            state <= START;
                            TX    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    TX    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at Baudrate=4, ADDR_W=2; inputs driven and outputs sampled on the falling edge.
module tb_uart_tx_fifo;
    localparam int BAUD = 4;
    localparam int AW   = 2;

    logic        Clk;
    logic        Reset;
    logic [7:0]  Data_in;
    logic        Wr_en;
    logic        Full;
    logic        Empty;
    logic [AW:0] Level;
    logic        Overflow;
    logic        TX;
    logic        Busy;
    logic        Done;

    int n_vec  = 0;
    int n_miss = 0;

    uart_tx_fifo #(.Baudrate(BAUD), .ADDR_W(AW)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Data_in  (Data_in),
        .Wr_en    (Wr_en),
        .Full     (Full),
        .Empty    (Empty),
        .Level    (Level),
        .Overflow (Overflow),
        .TX       (TX),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Samples the next 40 falling edges as one frame: start, LSB-first data, stop.
    task automatic check_frame(input logic [7:0] b);
        logic [9:0] frm;
        frm = {1'b1, b, 1'b0};
        for (int i = 1; i <= 10 * BAUD; i++) begin
            @(negedge Clk);
            check($sformatf("frm%02h_tx%0d", b, i), TX, frm[(i - 1) / BAUD]);
            check($sformatf("frm%02h_done%0d", b, i), Done, (i == 10 * BAUD));
            check($sformatf("frm%02h_busy%0d", b, i), Busy, 1'b1);
        end
    endtask

    task automatic idle_window(input string tag, input int n);
        int tx_low;
        int dones;
        int busys;
        tx_low = 0; dones = 0; busys = 0;
        repeat (n) begin
            @(negedge Clk);
            if (TX !== 1'b1) tx_low++;
            if (Done !== 1'b0) dones++;
            if (Busy !== 1'b0) busys++;
        end
        check({tag, "_txlow"}, tx_low, 0);
        check({tag, "_done"}, dones, 0);
        check({tag, "_busy"}, busys, 0);
        check({tag, "_empty"}, Empty, 1'b1);
        check({tag, "_level"}, Level, 0);
    endtask

    initial begin
        Reset   = 1'b1;
        Wr_en   = 1'b0;
        Data_in = 8'h00;
        repeat (3) @(negedge Clk);
        check("rst_tx", TX, 1'b1);
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_full", Full, 1'b0);
        check("rst_empty", Empty, 1'b1);
        check("rst_level", Level, 0);
        check("rst_ovf", Overflow, 1'b0);
        Reset = 1'b0;

        // 1: idle line
        idle_window("idle", 50);

        // 2: single byte 0xA5
        Data_in = 8'hA5; Wr_en = 1'b1;
        @(negedge Clk);
        Wr_en = 1'b0;
        check("a5_lat_tx", TX, 1'b1);
        check("a5_lat_level", Level, 1);
        check_frame(8'hA5);
        @(negedge Clk);
        check("a5_end_busy", Busy, 1'b0);
        check("a5_end_tx", TX, 1'b1);
        check("a5_end_empty", Empty, 1'b1);

        // 3: three back-to-back frames
        fork
            begin
                Data_in = 8'h01; Wr_en = 1'b1;
                @(negedge Clk); Data_in = 8'h80;
                @(negedge Clk); Data_in = 8'hFF;
                @(negedge Clk); Wr_en = 1'b0;
            end
            begin
                @(negedge Clk);
                check_frame(8'h01);
                check_frame(8'h80);
                check_frame(8'hFF);
            end
        join
        @(negedge Clk);
        check("b2b_end_busy", Busy, 1'b0);
        check("b2b_end_ovf", Overflow, 1'b0);

        // 4: overflow with six writes
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    if (k == 5) begin
                        check("ovf_full", Full, 1'b1);
                        check("ovf_level4", Level, 4);
                        check("ovf_pre", Overflow, 1'b0);
                    end
                    Data_in = 8'h10 + 8'(k); Wr_en = 1'b1;
                    @(negedge Clk);
                end
                Wr_en = 1'b0;
                check("ovf_set", Overflow, 1'b1);
                check("ovf_level_hold", Level, 4);
            end
            begin
                @(negedge Clk);
                check_frame(8'h10);
                check_frame(8'h11);
                check_frame(8'h12);
                check_frame(8'h13);
                check_frame(8'h14);
            end
        join
        @(negedge Clk);
        check("ovf_end_busy", Busy, 1'b0);
        check("ovf_end_empty", Empty, 1'b1);
        check("ovf_sticky", Overflow, 1'b1);

        // 5: reset in the middle of a 0x00 frame with another byte queued
        Data_in = 8'h00; Wr_en = 1'b1;
        @(negedge Clk); Data_in = 8'h33;
        @(negedge Clk); Wr_en = 1'b0;
        repeat (8) @(negedge Clk);
        check("mid_tx", TX, 1'b0);
        check("mid_level", Level, 1);
        Reset = 1'b1;
        #1;
        check("arst_tx", TX, 1'b1);
        check("arst_busy", Busy, 1'b0);
        check("arst_level", Level, 0);
        check("arst_ovf", Overflow, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        idle_window("post_rst", 50);

        // 6: write landing on the last stop cycle chains without a gap
        fork
            begin
                Data_in = 8'h5A; Wr_en = 1'b1;
                @(negedge Clk); Wr_en = 1'b0;
                repeat (39) @(negedge Clk);
                Data_in = 8'hC3; Wr_en = 1'b1;
                @(negedge Clk); Wr_en = 1'b0;
                @(negedge Clk);
                check("chain_level0", Level, 0);
            end
            begin
                @(negedge Clk);
                check_frame(8'h5A);
                check("chain_level1", Level, 1);
                check_frame(8'hC3);
            end
        join
        @(negedge Clk);
        check("chain_end_busy", Busy, 1'b0);
        check("chain_end_tx", TX, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
